decode_issue_ctrl: RTL and testbench

//  Sequences the decode stage between instruction fetch and execute. Buffers fetched

---
 rtl/decode_issue_ctrl_pkg.sv | 20 ++
 rtl/decode_issue_ctrl_inst_fifo.sv | 63 ++++++
 rtl/decode_issue_ctrl.sv | 88 ++++++++
 tb/tb_decode_issue_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode/issue controller: FSM encoding and the
// instruction encodings the controller reacts to.
package decode_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StSleep = 2'd2
  } state_e;

  localparam logic [4:0]  OpcSystem        = 5'b11100;
  localparam logic [31:0] InstWfi          = 32'h10500073;
  localparam logic [3:0]  CauseIllegalInst = 4'd2;

  // SYSTEM-major opcodes (CSR access, ecall, mret, wfi) must see an idle back end.
  function automatic logic is_serializing(input logic [6:0] opcode);
    return opcode[6:2] == OpcSystem;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_inst_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs between fetch and issue.
// Flush empties it on the next edge and overrides any concurrent push/pop.
module decode_issue_ctrl_inst_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q != CntW'(Depth)) & ~flush_i;
  assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer wrap is the natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: buffers fetch beats, issues to execute under valid/ready,
// serializes SYSTEM instructions, sleeps on WFI and discards everything on flush.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic            dec_en,
  output logic [XLEN-1:0] dec_inst,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  input  logic            ex_ready,
  input  logic            ex_busy,
  input  logic            flush,
  input  logic            irq_pending,
  output logic            illegal_trap,
  output logic            sleeping
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   count;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   head_inst, head_pc;
  logic              not_empty, serializing, push, pop;

  decode_issue_ctrl_inst_fifo #(
    .Depth(DEPTH),
    .Width(2 * XLEN)
  ) u_inst_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .wdata_i({if_pc, if_inst}),
    .pop_i  (pop),
    .flush_i(flush),
    .head_o (head),
    .count_o(count)
  );

  assign head_inst   = head[XLEN-1:0];
  assign head_pc     = head[2*XLEN-1:XLEN];
  assign not_empty   = (count != '0);
  assign serializing = is_serializing(head_inst[6:0]);
  assign push        = if_valid & if_ready;
  assign pop         = ex_valid & ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (not_empty && serializing && ex_busy)        state_d = StDrain;
          else if (pop && head_inst == XLEN'(InstWfi))    state_d = StSleep;
        end
        StDrain: if (!ex_busy)    state_d = StRun;
        StSleep: if (irq_pending) state_d = StRun;
        default:                  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    if_ready     = rst_n & ~flush & (count < CntW'(DEPTH)) & (state_q != StSleep);
    ex_valid     = (state_q == StRun) & not_empty & ~flush & ~(serializing & ex_busy);
    illegal_trap = ex_valid & (head_inst[1:0] != 2'b11);
    dec_en       = not_empty;
    dec_inst     = not_empty ? head_inst : '0;
    ex_pc        = not_empty ? head_pc : '0;
    sleeping     = (state_q == StSleep);
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl; a scoreboard queue checks issued PC/inst order.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        if_ready, dec_en, ex_valid, ex_ready, ex_busy, flush, irq_pending;
  logic [31:0] dec_inst, ex_pc;
  logic        illegal_trap, sleeping;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q [$];

  decode_issue_ctrl #(
    .DEPTH(2),
    .XLEN (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .dec_en      (dec_en),
    .dec_inst    (dec_inst),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_ready    (ex_ready),
    .ex_busy     (ex_busy),
    .flush       (flush),
    .irq_pending (irq_pending),
    .illegal_trap(illegal_trap),
    .sleeping    (sleeping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: issues are checked against the queue, accepted fetch beats are queued.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_issue", {32'h0, ex_pc}, 64'hdead);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("sb_issue_pc", {32'h0, ex_pc}, {32'h0, e[63:32]});
          chk("sb_issue_inst", {32'h0, dec_inst}, {32'h0, e[31:0]});
        end
      end
      if (if_valid && if_ready) exp_q.push_back({if_pc, if_inst});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; if_valid = 1'b1; if_inst = 32'h13; if_pc = 32'h4;
    ex_ready = 1'b1; ex_busy = 1'b0; flush = 1'b0; irq_pending = 1'b0;
    #3;
    chk("rst_ctl", {59'h0, if_ready, dec_en, ex_valid, illegal_trap, sleeping}, 64'h0);
    chk("rst_dec_inst", {32'h0, dec_inst}, 64'h0);
    chk("rst_ex_pc", {32'h0, ex_pc}, 64'h0);
    if_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Back-to-back ADDI stream, one issue per cycle with 1-cycle latency.
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1;
      v = 32'h13 | (32'(i + 1) << 20);
      if_inst = v;
      if_pc = 32'h100 + 32'(4 * i);
      @(negedge clk);
      chk("t1_if_ready", {63'h0, if_ready}, 64'h1);
      chk("t1_latency", {63'h0, ex_valid}, {63'h0, i > 0});
      if (i == 1) chk("t1_no_trap", {63'h0, illegal_trap}, 64'h0);
      tick();
    end
    if_valid = 1'b0;
    @(negedge clk);
    chk("t1_last_issue", {63'h0, ex_valid}, 64'h1);
    tick();
    @(negedge clk);
    chk("t1_empty", {62'h0, dec_en, ex_valid}, 64'h0);
    tick();

    // Back-pressure: three beats offered with ex_ready low, FIFO fills at two.
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1;
      if_inst = 32'h00a00093 + 32'(i << 7);
      if_pc = 32'h180 + 32'(4 * i);
      @(negedge clk);
      chk("t2_if_ready", {63'h0, if_ready}, {63'h0, i < 2});
      tick();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("t2_full_on_pop", {62'h0, if_ready, dec_en}, 64'h1);
    tick();
    @(negedge clk);
    chk("t2_slot_freed", {63'h0, if_ready}, 64'h1);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    chk("t2_last_issue", {63'h0, ex_valid}, 64'h1);
    tick();
    @(negedge clk);
    chk("t2_empty", {63'h0, dec_en}, 64'h0);
    tick();

    // CSRRW at head while execute is busy: hold in DRAIN, issue the cycle after busy drops.
    ex_busy = 1'b1;
    if_valid = 1'b1; if_inst = 32'h30529073; if_pc = 32'h200;
    @(negedge clk);
    tick();
    if_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_drain_hold", {62'h0, dec_en, ex_valid}, 64'h2);
      tick();
    end
    ex_busy = 1'b0;
    @(negedge clk);
    chk("t3_drain_exit", {63'h0, ex_valid}, 64'h0);
    tick();
    @(negedge clk);
    chk("t3_issue", {63'h0, ex_valid}, 64'h1);
    tick();

    // WFI puts the controller to sleep until an interrupt is pending.
    if_valid = 1'b1; if_inst = 32'h10500073; if_pc = 32'h300;
    @(negedge clk);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    chk("t4_wfi_issue", {63'h0, ex_valid}, 64'h1);
    tick();
    if_valid = 1'b1; if_inst = 32'h00100113; if_pc = 32'h304;
    @(negedge clk);
    chk("t4_sleep", {61'h0, sleeping, if_ready, ex_valid}, 64'h4);
    tick();
    irq_pending = 1'b1;
    @(negedge clk);
    chk("t4_sleep_irq", {62'h0, sleeping, if_ready}, 64'h2);
    tick();
    irq_pending = 1'b0;
    @(negedge clk);
    chk("t4_wake", {62'h0, sleeping, if_ready}, 64'h1);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    chk("t4_resume_issue", {63'h0, ex_valid}, 64'h1);
    tick();

    // Flush with the FIFO full and a concurrent push.
    ex_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00500293; if_pc = 32'h400;
    @(negedge clk);
    tick();
    if_inst = 32'h00600313; if_pc = 32'h404;
    @(negedge clk);
    tick();
    if_inst = 32'h00700393; if_pc = 32'h408; flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_same", {61'h0, dec_en, if_ready, ex_valid}, 64'h4);
    tick();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    chk("t5_flushed", {62'h0, dec_en, ex_valid}, 64'h0);
    tick();
    @(negedge clk);
    chk("t5_no_ghost", {63'h0, ex_valid}, 64'h0);
    tick();

    // Compressed-looking encoding flags an illegal trap on issue.
    if_valid = 1'b1; if_inst = 32'h00000011; if_pc = 32'h500;
    @(negedge clk);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    chk("t6_illegal", {62'h0, ex_valid, illegal_trap}, 64'h3);
    tick();

    // Asynchronous reset mid-stream zeros every output immediately.
    ex_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00200193; if_pc = 32'h600;
    @(negedge clk);
    tick();
    if_inst = 32'h00300213; if_pc = 32'h604;
    @(negedge clk);
    chk("t6_pre_rst", {63'h0, dec_en}, 64'h1);
    tick();
    if_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {59'h0, if_ready, dec_en, ex_valid, illegal_trap, sleeping}, 64'h0);
    chk("t6_rst_bus", {dec_inst, ex_pc}, 64'h0);
    @(negedge clk);
    tick();
    rst_n = 1'b1; ex_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_rst", {61'h0, if_ready, dec_en, ex_valid}, 64'h4);
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
